// File: rtl/jtcontra_rom_arb.sv
// jtcontra_rom_arb: two-requester arbiter for the 007121 16-bit graphics ROM slot.
// Build option JTCONTRA_ARB_HBLANK_EN: contention is resolved by LHBL instead of PRIO/round-robin.
//
// state | meaning
// IDLE  | no access in flight, rom_cs low, arbitrate pending requesters
// REQ   | rom_cs high on the latched address, waiting for a non-stale rom_ok
// GAP   | one rom_cs-low cycle after an access; also arbitrates for the next one

module jtcontra_rom_arb #(
  parameter int AW   = 18,
  parameter int PRIO = 0,
  parameter int TOUT = 255
) (
  input  logic          clk24,
  input  logic          rst,
  input  logic          LHBL,
  input  logic          cs0,
  input  logic [AW-1:0] addr0,
  output logic [15:0]   data0,
  output logic          ok0,
  input  logic          cs1,
  input  logic [AW-1:0] addr1,
  output logic [15:0]   data1,
  output logic          ok1,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  input  logic          rom_ok,
  output logic          tout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2} state_t;

  localparam logic [7:0] TOUT_C = 8'(TOUT);

  state_t        state_q, state_d;
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]   data0_q, data0_d, data1_q, data1_d;
  logic [AW-1:0] lat0_q, lat0_d, lat1_q, lat1_d;
  logic          valid0_q, valid0_d, valid1_q, valid1_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          tout_q, tout_d;

  logic hit0, hit1, pend0, pend1, both_g, gnt;

  assign hit0  = valid0_q & (addr0 == lat0_q);
  assign hit1  = valid1_q & (addr1 == lat1_q);
  assign pend0 = cs0 & ~hit0;
  assign pend1 = cs1 & ~hit1;

`ifdef JTCONTRA_ARB_HBLANK_EN
  // Active line favours the tile fetcher, blanking favours the object fetcher
  assign both_g = ~LHBL;
`else
  logic unused_lhbl;
  assign unused_lhbl = LHBL;
  assign both_g = (PRIO != 0) ? 1'b0 : ~last_q;
`endif

  assign gnt = (pend0 & pend1) ? both_g : pend1;

  always_comb begin
    state_d    = state_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    lat0_d     = lat0_q;
    lat1_d     = lat1_q;
    valid0_d   = valid0_q;
    valid1_d   = valid1_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    tout_d     = tout_q;
    case (state_q)
      // GAP grants directly so back-to-back accesses see exactly one low rom_cs cycle
      IDLE, GAP: begin
        state_d = IDLE;
        if (pend0 | pend1) begin
          state_d    = REQ;
          rom_cs_d   = 1'b1;
          rom_addr_d = gnt ? addr1 : addr0;
          cnt_d      = 8'd0;
          last_d     = gnt;
          if (gnt) valid1_d = 1'b0;
          else     valid0_d = 1'b0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        // rom_ok during the first rom_cs cycle may belong to the previous access
        if (rom_ok && cnt_q != 8'd0) begin
          rom_cs_d = 1'b0;
          state_d  = GAP;
          if (last_q) begin
            data1_d  = rom_data;
            lat1_d   = rom_addr_q;
            valid1_d = 1'b1;
          end else begin
            data0_d  = rom_data;
            lat0_d   = rom_addr_q;
            valid0_d = 1'b1;
          end
        end else if (cnt_q == TOUT_C) begin
          rom_cs_d = 1'b0;
          tout_d   = 1'b1;
          state_d  = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk24) begin
    if (rst) begin
      state_q    <= IDLE;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      data0_q    <= 16'd0;
      data1_q    <= 16'd0;
      lat0_q     <= '0;
      lat1_q     <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      cnt_q      <= 8'd0;
      last_q     <= 1'b1;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      lat0_q     <= lat0_d;
      lat1_q     <= lat1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      tout_q     <= tout_d;
    end
  end

  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign data0    = data0_q;
  assign data1    = data1_q;
  assign tout_err = tout_q;
  assign ok0      = cs0 & hit0;
  assign ok1      = cs1 & hit1;

endmodule

// File: tb/tb_jtcontra_rom_arb.sv
// Self-checking bench for jtcontra_rom_arb: SDRAM responder model plus a transaction-level
// arbitration model (grant order, latched addresses, stored data).
module tb_jtcontra_rom_arb;
  localparam int AW   = 18;
  localparam int TOUT = 8;

  logic          clk24 = 1'b0;
  logic          rst   = 1'b1;
  logic          LHBL  = 1'b1;
  logic          cs0   = 1'b0;
  logic          cs1   = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic [15:0]   data0, data1;
  logic          ok0, ok1, rom_cs, tout_err;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'd0;
  logic          rom_ok   = 1'b0;

  int errors = 0;
  int checks = 0;

  // SDRAM responder configuration
  bit sd_en    = 1'b1;
  bit sd_stale = 1'b0;
  int sd_lat   = 3;
  int sd_cnt   = 0;

  // Reference model state
  bit            last_m = 1'b1;
  logic [AW-1:0] lat_m0 = '0;
  logic [AW-1:0] lat_m1 = '0;

  jtcontra_rom_arb #(.AW(AW), .PRIO(0), .TOUT(TOUT)) dut (
    .clk24(clk24), .rst(rst), .LHBL(LHBL),
    .cs0(cs0), .addr0(addr0), .data0(data0), .ok0(ok0),
    .cs1(cs1), .addr1(addr1), .data1(data1), .ok1(ok1),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
    .tout_err(tout_err)
  );

  always #5 clk24 = ~clk24;

  function automatic logic [15:0] mem_f(input logic [AW-1:0] a);
    if (a == 18'h01234) return 16'hBEEF;
    return 16'(a * 7919) ^ 16'h5A5A;
  endfunction

  // Contended winner: round-robin against last grant, or LHBL when the option is built in
  function automatic bit pick_both(input bit last, input logic lhbl);
`ifdef JTCONTRA_ARB_HBLANK_EN
    return !lhbl;
`else
    return !last;
`endif
  endfunction

  always begin
    @(posedge clk24); #1;
    if (!rom_cs) begin
      sd_cnt = 0;
      rom_ok = 1'b0;
    end else begin
      if (sd_stale && sd_cnt == 0) begin
        rom_ok = 1'b1; rom_data = 16'hDEAD;
      end else if (sd_en && sd_cnt == sd_lat) begin
        rom_ok = 1'b1; rom_data = mem_f(rom_addr);
      end else begin
        rom_ok = 1'b0; rom_data = 16'h0000;
      end
      sd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk24); #1;
  endtask

  function automatic bit sig_now(input int which);
    case (which)
      0: return rom_cs === 1'b1;
      1: return ok0 === 1'b1;
      2: return ok1 === 1'b1;
      default: return rom_cs === 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, output bit hit);
    hit = sig_now(which);
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      hit = sig_now(which);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cs0 = 1'b1; addr0 = '0;
    repeat (3) tick();
    checks++; if (ok0 !== 1'b0) begin errors++; $display("FAIL reset_ok0: got %b want 0", ok0); end
    cs0 = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
    checks++; if (data0 !== 16'd0 || data1 !== 16'd0) begin errors++; $display("FAIL reset_data: got %h/%h want 0/0", data0, data1); end
    checks++; if (tout_err !== 1'b0) begin errors++; $display("FAIL reset_tout: got %b want 0", tout_err); end
    last_m = 1'b1; lat_m0 = '0; lat_m1 = '0;
  endtask

  task automatic test_contention();
    logic [AW-1:0] a0, a1;
    bit first, hit;
    sd_en = 1'b1; sd_stale = 1'b0; sd_lat = 2; LHBL = 1'b1;
    for (int round = 0; round < 2; round++) begin
      a0 = 18'h00100 + 18'(round); a1 = 18'h20200 + 18'(round);
      first = pick_both(last_m, LHBL);
      cs0 = 1'b1; cs1 = 1'b1; addr0 = a0; addr1 = a1;
      tick();
      checks++; if (rom_cs !== 1'b1 || rom_addr !== (first ? a1 : a0)) begin
        errors++; $display("FAIL contend_first r%0d: got cs=%b addr=%h want cs=1 addr=%h", round, rom_cs, rom_addr, first ? a1 : a0); end
      wait_for(first ? 2 : 1, 12, hit);
      checks++; if (!hit || (first ? data1 : data0) !== mem_f(first ? a1 : a0)) begin
        errors++; $display("FAIL contend_data1 r%0d: got hit=%b data=%h want %h", round, hit, first ? data1 : data0, mem_f(first ? a1 : a0)); end
      checks++; if (rom_cs !== 1'b0 || (first ? ok0 : ok1) !== 1'b0) begin
        errors++; $display("FAIL contend_gap r%0d: got rom_cs=%b other_ok=%b want 0/0", round, rom_cs, first ? ok0 : ok1); end
      tick();
      checks++; if (rom_cs !== 1'b1 || rom_addr !== (first ? a0 : a1)) begin
        errors++; $display("FAIL contend_second r%0d: got cs=%b addr=%h want cs=1 addr=%h", round, rom_cs, rom_addr, first ? a0 : a1); end
      wait_for(first ? 1 : 2, 12, hit);
      checks++; if (!hit || (first ? data0 : data1) !== mem_f(first ? a0 : a1)) begin
        errors++; $display("FAIL contend_data2 r%0d: got hit=%b data=%h want %h", round, hit, first ? data0 : data1, mem_f(first ? a0 : a1)); end
      last_m = !first; lat_m0 = a0; lat_m1 = a1;
      cs0 = 1'b0; cs1 = 1'b0;
      repeat (2) tick();
      if (round == 0) begin
        cs0 = 1'b1; addr0 = 18'h00ABC;
        wait_for(1, 14, hit);
        checks++; if (!hit || data0 !== mem_f(18'h00ABC)) begin
          errors++; $display("FAIL contend_solo: got hit=%b data=%h want %h", hit, data0, mem_f(18'h00ABC)); end
        last_m = 1'b0; lat_m0 = 18'h00ABC;
        cs0 = 1'b0;
        repeat (2) tick();
      end
    end
  endtask

  task automatic test_single();
    sd_en = 1'b1; sd_stale = 1'b0; sd_lat = 3;
    cs0 = 1'b1; addr0 = 18'h01234;
    tick();
    checks++; if (rom_cs !== 1'b1 || rom_addr !== 18'h01234) begin
      errors++; $display("FAIL single_req: got cs=%b addr=%h want 1/01234", rom_cs, rom_addr); end
    repeat (3) tick();
    checks++; if (ok0 !== 1'b0) begin errors++; $display("FAIL single_early_ok: got %b want 0", ok0); end
    tick();
    checks++; if (ok0 !== 1'b1 || data0 !== 16'hBEEF || rom_cs !== 1'b0) begin
      errors++; $display("FAIL single_resp: got ok=%b data=%h cs=%b want 1/beef/0", ok0, data0, rom_cs); end
    last_m = 1'b0; lat_m0 = 18'h01234;
    cs0 = 1'b0;
    #1;
    checks++; if (ok0 !== 1'b0) begin errors++; $display("FAIL single_drop_cs: got ok=%b want 0", ok0); end
    repeat (2) tick();
  endtask

  task automatic test_addr_change();
    bit hit;
    sd_lat = 3;
    cs0 = 1'b1; addr0 = 18'h00010;
    tick();
    checks++; if (rom_addr !== 18'h00010) begin errors++; $display("FAIL chg_addr1: got %h want 00010", rom_addr); end
    tick();
    addr0 = 18'h00011;
    wait_for(3, 12, hit);
    checks++; if (!hit || ok0 !== 1'b0 || data0 !== mem_f(18'h00010)) begin
      errors++; $display("FAIL chg_first: got hit=%b ok=%b data=%h want 1/0/%h", hit, ok0, data0, mem_f(18'h00010)); end
    tick();
    checks++; if (rom_cs !== 1'b1 || rom_addr !== 18'h00011) begin
      errors++; $display("FAIL chg_retry: got cs=%b addr=%h want 1/00011", rom_cs, rom_addr); end
    wait_for(1, 12, hit);
    checks++; if (!hit || data0 !== mem_f(18'h00011)) begin
      errors++; $display("FAIL chg_second: got hit=%b data=%h want %h", hit, data0, mem_f(18'h00011)); end
    last_m = 1'b0; lat_m0 = 18'h00011;
    cs0 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_stale();
    bit hit;
    sd_stale = 1'b1; sd_lat = 2;
    cs1 = 1'b1; addr1 = 18'h3A5C1;
    tick();
    tick();
    checks++; if (ok1 !== 1'b0 || rom_cs !== 1'b1) begin
      errors++; $display("FAIL stale_ignored: got ok=%b cs=%b want 0/1", ok1, rom_cs); end
    wait_for(2, 12, hit);
    checks++; if (!hit || data1 !== mem_f(18'h3A5C1)) begin
      errors++; $display("FAIL stale_data: got hit=%b data=%h want %h", hit, data1, mem_f(18'h3A5C1)); end
    sd_stale = 1'b0;
    last_m = 1'b1; lat_m1 = 18'h3A5C1;
    cs1 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int n;
    bit hit;
    sd_en = 1'b0;
    cs1 = 1'b1; addr1 = 18'h05555;
    tick();
    n = 0;
    while (rom_cs === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n != TOUT + 1) begin errors++; $display("FAIL tout_len: got %0d rom_cs cycles want %0d", n, TOUT + 1); end
    checks++; if (tout_err !== 1'b1 || ok1 !== 1'b0) begin
      errors++; $display("FAIL tout_flag: got err=%b ok1=%b want 1/0", tout_err, ok1); end
    cs1 = 1'b0;
    last_m = 1'b1;
    sd_en = 1'b1; sd_lat = 1;
    repeat (3) tick();
    cs1 = 1'b1;
    wait_for(2, 12, hit);
    checks++; if (!hit || data1 !== mem_f(18'h05555) || tout_err !== 1'b1) begin
      errors++; $display("FAIL tout_recover: got hit=%b data=%h err=%b want 1/%h/1", hit, data1, tout_err, mem_f(18'h05555)); end
    lat_m1 = 18'h05555;
    cs1 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [AW-1:0] a0, a1;
    int r;
    bit first, both, hit;
    for (int it = 0; it < 30; it++) begin
      r = int'($urandom_range(1, 3));
      both = (r == 3);
      LHBL = 1'($urandom);
      sd_lat = int'($urandom_range(1, 4));
      sd_stale = 1'($urandom);
      a0 = AW'($urandom); if (a0 == lat_m0) a0 = a0 ^ 18'h1;
      a1 = AW'($urandom); if (a1 == lat_m1) a1 = a1 ^ 18'h1;
      first = both ? pick_both(last_m, LHBL) : (r == 2);
      cs0 = r[0]; cs1 = r[1]; addr0 = a0; addr1 = a1;
      tick();
      checks++; if (rom_cs !== 1'b1 || rom_addr !== (first ? a1 : a0)) begin
        errors++; $display("FAIL rnd_grant it%0d: got cs=%b addr=%h want 1/%h", it, rom_cs, rom_addr, first ? a1 : a0); end
      wait_for(first ? 2 : 1, 12, hit);
      checks++; if (!hit || (first ? data1 : data0) !== mem_f(first ? a1 : a0) || rom_cs !== 1'b0) begin
        errors++; $display("FAIL rnd_data it%0d: got hit=%b data=%h cs=%b want %h", it, hit, first ? data1 : data0, rom_cs, mem_f(first ? a1 : a0)); end
      if (both) begin
        tick();
        checks++; if (rom_cs !== 1'b1 || rom_addr !== (first ? a0 : a1)) begin
          errors++; $display("FAIL rnd_grant2 it%0d: got cs=%b addr=%h want 1/%h", it, rom_cs, rom_addr, first ? a0 : a1); end
        wait_for(first ? 1 : 2, 12, hit);
        checks++; if (!hit || ok0 !== 1'b1 || ok1 !== 1'b1 || (first ? data0 : data1) !== mem_f(first ? a0 : a1)) begin
          errors++; $display("FAIL rnd_data2 it%0d: got hit=%b ok=%b%b data=%h want %h", it, hit, ok0, ok1, first ? data0 : data1, mem_f(first ? a0 : a1)); end
        last_m = !first;
        lat_m0 = a0; lat_m1 = a1;
      end else begin
        last_m = first;
        if (first) lat_m1 = a1; else lat_m0 = a0;
      end
      cs0 = 1'b0; cs1 = 1'b0;
      tick();
      checks++; if (ok0 !== 1'b0 || ok1 !== 1'b0 || rom_cs !== 1'b0) begin
        errors++; $display("FAIL rnd_idle it%0d: got ok=%b%b cs=%b want 00/0", it, ok0, ok1, rom_cs); end
    end
    sd_stale = 1'b0; LHBL = 1'b1;
  endtask

`ifdef JTCONTRA_ARB_HBLANK_EN
  task automatic test_hblank();
    bit hit, h2;
    sd_lat = 2;
    for (int k = 0; k < 2; k++) begin
      LHBL = (k == 1);
      cs0 = 1'b1; cs1 = 1'b1; addr0 = 18'h01100 + 18'(k); addr1 = 18'h02200 + 18'(k);
      tick();
      checks++; if (rom_addr !== (k == 1 ? addr0 : addr1)) begin
        errors++; $display("FAIL hblank_grant lhbl=%0d: got %h want %h", k, rom_addr, k == 1 ? addr0 : addr1); end
      wait_for(1, 30, hit);
      wait_for(2, 30, h2);
      last_m = (k == 1); lat_m0 = addr0; lat_m1 = addr1;
      cs0 = 1'b0; cs1 = 1'b0;
      repeat (3) tick();
    end
  endtask
`endif

  task automatic test_reset_mid();
    cs0 = 1'b1; addr0 = 18'h0F0F0; sd_lat = 3;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (rom_cs !== 1'b0 || tout_err !== 1'b0 || data0 !== 16'd0 || data1 !== 16'd0) begin
      errors++; $display("FAIL rst_mid: got cs=%b err=%b data=%h/%h want 0/0/0/0", rom_cs, tout_err, data0, data1); end
    rst = 1'b0; cs0 = 1'b0;
    repeat (5) tick();
    checks++; if (rom_cs !== 1'b0 || ok0 !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: got cs=%b ok0=%b want 0/0", rom_cs, ok0); end
    last_m = 1'b1; lat_m0 = '0; lat_m1 = '0;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_addr_change();
    test_stale();
    test_timeout();
    test_random();
`ifdef JTCONTRA_ARB_HBLANK_EN
    test_hblank();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
